// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: instruction fetch (index 0) and data load
// (index 1) share one AXI read-address/read-data channel pair. Only one read
// transaction is outstanding; response beats are routed back by the grant.
module axi_read_arbiter #(
    parameter int         ARB_MODE = 0,     // 0: round-robin, 1: data (index 1) wins
    parameter logic [3:0] ID_BASE  = 4'h0   // ARID for index 0; index 1 uses ID_BASE+1
) (
    input  logic        clk,
    input  logic        reset,              // synchronous, active-low
    // requester side
    input  logic [1:0]  m_arvalid,
    input  logic [63:0] m_araddr,
    input  logic [15:0] m_arlen,
    input  logic [5:0]  m_arsize,
    output logic [1:0]  m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rvalid,
    output logic        m_rlast,
    input  logic [1:0]  m_rready,
    // AXI read-address channel
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    // AXI read-response channel
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t      r_state;
    logic        r_gnt;        // index owning the transaction in flight
    logic        r_last_gnt;   // index that completed the previous transaction
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;
    logic        r_arvalid;

    logic        w_gnt;
    logic        w_take;
    logic        w_rready;
    logic        w_unused;

    // Routing uses the grant only, so the response ID and status are not consulted.
    assign w_unused = ^{RID, RRESP};

    // Pick the winner among the current requests.
    always_comb begin
        w_gnt = 1'b0;
        if (m_arvalid == 2'b11) begin
            w_gnt = (ARB_MODE == 1) ? 1'b1 : ~r_last_gnt;
        end else begin
            w_gnt = m_arvalid[1];
        end
    end

    // A request is accepted only in IDLE and never while reset is asserted.
    assign w_take    = (r_state == S_IDLE) && reset && (|m_arvalid);
    assign m_arready = w_take ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

    // Response beats go only to the granted requester, and only in DATA.
    always_comb begin
        m_rvalid = 2'b00;
        w_rready = 1'b0;
        if (r_state == S_DATA) begin
            m_rvalid[r_gnt] = RVALID;
            w_rready        = m_rready[r_gnt];
        end
    end

    assign RREADY  = w_rready;
    assign m_rdata = RDATA;
    assign m_rlast = RLAST;

    assign ARID    = r_arid;
    assign ARADDR  = r_araddr;
    assign ARLEN   = r_arlen;
    assign ARSIZE  = r_arsize;
    assign ARBURST = r_arburst;
    assign ARVALID = r_arvalid;

    // Transaction FSM: capture on grant, hold the address until accepted, then
    // stay in DATA until the last beat handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_arid     <= 4'h0;
            r_araddr   <= 32'h0;
            r_arlen    <= 8'h0;
            r_arsize   <= 3'h0;
            r_arburst  <= 2'b00;
            r_arvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|m_arvalid) begin
                        r_gnt     <= w_gnt;
                        r_araddr  <= w_gnt ? m_araddr[63:32] : m_araddr[31:0];
                        r_arlen   <= w_gnt ? m_arlen[15:8]   : m_arlen[7:0];
                        r_arsize  <= w_gnt ? m_arsize[5:3]   : m_arsize[2:0];
                        r_arid    <= ID_BASE + {3'b000, w_gnt};
                        r_arburst <= 2'b01;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (RVALID && w_rready && RLAST) begin
                        r_last_gnt <= r_gnt;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: a round-robin instance and a fixed-priority
// instance share identical stimulus and are compared against a grant model.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  m_arvalid;
    logic [63:0] m_araddr;
    logic [15:0] m_arlen;
    logic [5:0]  m_arsize;
    logic [1:0]  m_rready;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;

    logic [1:0]  m_arready_a, m_rvalid_a, ARBURST_a;
    logic [31:0] m_rdata_a, ARADDR_a;
    logic        m_rlast_a, ARVALID_a, RREADY_a;
    logic [3:0]  ARID_a;
    logic [7:0]  ARLEN_a;
    logic [2:0]  ARSIZE_a;

    logic [1:0]  m_arready_b, m_rvalid_b, ARBURST_b;
    logic [31:0] m_rdata_b, ARADDR_b;
    logic        m_rlast_b, ARVALID_b, RREADY_b;
    logic [3:0]  ARID_b;
    logic [7:0]  ARLEN_b;
    logic [2:0]  ARSIZE_b;

    localparam logic [3:0] BASE_B = 4'h8;

    axi_read_arbiter #(.ARB_MODE(0), .ID_BASE(4'h0)) dut_a (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arready(m_arready_a), .m_rdata(m_rdata_a), .m_rvalid(m_rvalid_a),
        .m_rlast(m_rlast_a), .m_rready(m_rready),
        .ARID(ARID_a), .ARADDR(ARADDR_a), .ARLEN(ARLEN_a), .ARSIZE(ARSIZE_a),
        .ARBURST(ARBURST_a), .ARVALID(ARVALID_a), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY_a)
    );

    axi_read_arbiter #(.ARB_MODE(1), .ID_BASE(BASE_B)) dut_b (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arready(m_arready_b), .m_rdata(m_rdata_b), .m_rvalid(m_rvalid_b),
        .m_rlast(m_rlast_b), .m_rready(m_rready),
        .ARID(ARID_b), .ARADDR(ARADDR_b), .ARLEN(ARLEN_b), .ARSIZE(ARSIZE_b),
        .ARBURST(ARBURST_b), .ARVALID(ARVALID_b), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY_b)
    );

    int checks = 0;
    int errors = 0;
    int last_a;
    int last_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration rule: lone requester wins; on contention either the
    // one not served last (mode 0) or the data requester (mode 1).
    function automatic int pick(input logic [1:0] req, input int mode, input int last);
        if (req == 2'b11) return (mode == 1) ? 1 : 1 - last;
        return req[1] ? 1 : 0;
    endfunction

    // One full transaction starting at a negedge with both instances in IDLE.
    task automatic txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1,
                       input logic [2:0] s0, input logic [2:0] s1,
                       input int ardly, input int nbeats, input int stall_beat);
        int ga, gb, beat, guard;
        bit stalled;
        logic [1:0] rr, erv_a, erv_b;
        ga = pick(req, 0, last_a);
        gb = pick(req, 1, last_b);
        m_arvalid = req;
        m_araddr  = {a1, a0};
        m_arlen   = {l1, l0};
        m_arsize  = {s1, s0};
        RVALID    = 1'($urandom_range(0, 1));
        RLAST     = 1'($urandom_range(0, 1));
        m_rready  = 2'b11;
        ARREADY   = 1'($urandom_range(0, 1));
        #1;
        chk("grant_a", m_arready_a, 2'b01 << ga);
        chk("grant_b", m_arready_b, 2'b01 << gb);
        chk("idle_rvalid_a", m_rvalid_a, 2'b00);
        chk("idle_rready_a", RREADY_a, 1'b0);
        chk("idle_rready_b", RREADY_b, 1'b0);
        @(negedge clk);
        // address phase: inputs scrambled, captured values must hold
        for (int c = 0; c <= ardly; c++) begin
            m_arvalid = 2'($urandom_range(0, 3));
            m_araddr  = {$urandom, $urandom};
            m_arlen   = 16'($urandom);
            m_arsize  = 6'($urandom);
            m_rready  = 2'($urandom);
            RVALID    = 1'($urandom_range(0, 1));
            ARREADY   = (c == ardly);
            #1;
            chk("arvalid_a", ARVALID_a, 1'b1);
            chk("araddr_a", ARADDR_a, (ga == 1) ? a1 : a0);
            chk("arlen_a", ARLEN_a, (ga == 1) ? l1 : l0);
            chk("arsize_a", ARSIZE_a, (ga == 1) ? s1 : s0);
            chk("arid_a", ARID_a, 4'(ga));
            chk("arburst_a", ARBURST_a, 2'b01);
            chk("arvalid_b", ARVALID_b, 1'b1);
            chk("araddr_b", ARADDR_b, (gb == 1) ? a1 : a0);
            chk("arid_b", ARID_b, BASE_B + 4'(gb));
            chk("hold_arready_a", m_arready_a, 2'b00);
            chk("hold_arready_b", m_arready_b, 2'b00);
            chk("addr_rvalid_a", m_rvalid_a, 2'b00);
            chk("addr_rready_a", RREADY_a, 1'b0);
            @(negedge clk);
        end
        ARREADY = 1'b0;
        // data phase
        beat = 0;
        guard = 0;
        stalled = 1'b0;
        while (beat < nbeats && guard < 200) begin
            guard++;
            rr = 2'($urandom);
            RVALID = ($urandom_range(0, 3) != 0);
            if (beat == stall_beat && !stalled) begin
                RVALID = 1'b1;
                rr = 2'b00;
                stalled = 1'b1;
            end
            if (ga != gb) rr = {rr[0], rr[0]};
            m_rready  = rr;
            m_arvalid = 2'($urandom_range(0, 3));
            RDATA = $urandom;
            RID   = 4'($urandom);
            RRESP = 2'($urandom);
            RLAST = RVALID ? (beat == nbeats - 1) : 1'($urandom_range(0, 1));
            erv_a = (ga == 1) ? {RVALID, 1'b0} : {1'b0, RVALID};
            erv_b = (gb == 1) ? {RVALID, 1'b0} : {1'b0, RVALID};
            #1;
            chk("rvalid_a", m_rvalid_a, erv_a);
            chk("rvalid_b", m_rvalid_b, erv_b);
            chk("rready_a", RREADY_a, rr[ga]);
            chk("rready_b", RREADY_b, rr[gb]);
            chk("rdata_a", m_rdata_a, RDATA);
            chk("rlast_a", m_rlast_a, RLAST);
            chk("data_arvalid_a", ARVALID_a, 1'b0);
            chk("data_arready_a", m_arready_a, 2'b00);
            chk("data_arready_b", m_arready_b, 2'b00);
            if (RVALID && rr[ga]) beat++;
            @(negedge clk);
        end
        chk("beats_done", beat, nbeats);
        RVALID = 1'b0;
        RLAST  = 1'b0;
        m_arvalid = 2'b00;
        last_a = ga;
        last_b = gb;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] req;
        reset = 1'b0;
        m_arvalid = 2'b11;
        m_araddr = 64'h1234_5678_9abc_def0;
        m_arlen = 16'h0;
        m_arsize = 6'h0;
        m_rready = 2'b11;
        ARREADY = 1'b1;
        RID = 4'h0;
        RDATA = 32'h0;
        RRESP = 2'b00;
        RLAST = 1'b0;
        RVALID = 1'b1;
        last_a = 1;
        last_b = 1;

        // reset state, with requests present
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arvalid", ARVALID_a, 1'b0);
        chk("rst_arid", ARID_b, 4'h0);
        chk("rst_araddr", ARADDR_a, 32'h0);
        chk("rst_arlen", ARLEN_a, 8'h0);
        chk("rst_arsize", ARSIZE_a, 3'h0);
        chk("rst_arburst", ARBURST_a, 2'b00);
        chk("rst_arready_a", m_arready_a, 2'b00);
        chk("rst_arready_b", m_arready_b, 2'b00);
        chk("rst_rready", RREADY_a, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        m_arvalid = 2'b00;
        RVALID = 1'b0;
        ARREADY = 1'b0;

        // contention: mode 0 alternates starting at 0, mode 1 always 1
        for (int i = 0; i < 4; i++)
            txn(2'b11, $urandom, $urandom, 8'($urandom), 8'($urandom), 3'($urandom),
                3'($urandom), 0, 1, -1);

        // single instruction fetch, immediate ARREADY, single beat
        txn(2'b01, 32'hBFC00000, 32'h0, 8'h0, 8'h0, 3'h2, 3'h0, 0, 1, -1);

        // address phase stretched by 5 cycles of ARREADY low
        txn(2'b01, 32'h8000_1000, 32'h0, 8'h0, 8'h0, 3'h2, 3'h0, 5, 1, -1);

        // 4-beat burst to the data requester, ready withheld on beat 2
        txn(2'b10, 32'h0, 32'h4000_0040, 8'h0, 8'h3, 3'h0, 3'h2, 1, 4, 2);

        // randomized traffic with idle gaps
        for (int i = 0; i < 30; i++) begin
            req = 2'($urandom_range(1, 3));
            txn(req, $urandom, $urandom, 8'($urandom), 8'($urandom), 3'($urandom),
                3'($urandom), $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 4) - 1);
            if ($urandom_range(0, 1) == 1) begin
                RVALID = 1'b1;
                m_rready = 2'b11;
                #1;
                chk("gap_rvalid_a", m_rvalid_a, 2'b00);
                chk("gap_rready_b", RREADY_b, 1'b0);
                chk("gap_arvalid_b", ARVALID_b, 1'b0);
                @(negedge clk);
                RVALID = 1'b0;
            end
        end

        // reset asserted in the middle of DATA
        m_arvalid = 2'b01;
        m_araddr = 64'h0000_0000_0000_2000;
        @(negedge clk);
        m_arvalid = 2'b00;
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        RVALID = 1'b1;
        RLAST = 1'b0;
        m_rready = 2'b11;
        #1;
        chk("pre_rst_rvalid_a", m_rvalid_a, 2'b01);
        reset = 1'b0;
        m_arvalid = 2'b11;
        @(negedge clk);
        #1;
        chk("mid_rst_arvalid_a", ARVALID_a, 1'b0);
        chk("mid_rst_rready_a", RREADY_a, 1'b0);
        chk("mid_rst_rready_b", RREADY_b, 1'b0);
        chk("mid_rst_rvalid_a", m_rvalid_a, 2'b00);
        chk("mid_rst_arready_a", m_arready_a, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        RVALID = 1'b0;
        last_a = 1;
        last_b = 1;
        txn(2'b11, 32'hA000_0000, 32'hB000_0000, 8'h1, 8'h2, 3'h2, 3'h2, 0, 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
